alu_result_collector: RTL and testbench
=======================================

Name: alu_result_collector

Overview:
- Downstream consumer for the pipelined ALU result stream (res / out_databits / out_op).
- Captures every non-NOP result with its tag and opcode into a first-word-fall-through FIFO. Software or a bench drains the FIFO through a valid/ready read port.
- Checks that result tags arrive in consecutive order and flags drops and sequence errors for the test environment.

Parameters:
- WIDTH, 32, result data width (matches the ALU `WIDTH).
- DATABITS, 7, tag width (matches the ALU `DATABITS).
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
- AW, 3, log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low. Asserted (0) clears all state immediately.
- res  input  WIDTH  ALU result.
- out_databits  input  DATABITS  ALU result tag.
- out_op  input  2  ALU result opcode: 0=NOP, 1=ADD, 2=SUB, 3=MULT.
- rd_ready  input  1  consumer accepts the head entry.
- clear  input  1  synchronous clear of status flags and counters.
- rd_valid  output  1  FIFO non-empty.
- rd_res  output  WIDTH  head entry result.
- rd_tag  output  DATABITS  head entry tag.
- rd_op  output  2  head entry opcode.
- count  output  AW+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a result was dropped because the FIFO was full.
- drop_count  output  8  saturating count of dropped results.
- seq_error  output  1  sticky: a tag arrived out of sequence.
- err_tag  output  DATABITS  tag that caused the first unclearedseq_error.

Behaviour:
- Reset (reset=0, async): FIFO empty, count=0, rd_valid=0, rd_res/rd_tag/rd_op=0, overflow=0, drop_count=0, seq_error=0, err_tag=0, expected tag=0.
- Arrival:
  - Each posedge with out_op!=0 is an arrival.
  - out_op=0 is a bubble and is ignored entirely, including by the sequence checker.
- Push: an arrival is written to the tail if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle (simultaneous pop frees the slot).
- Drop:
  - An arrival with count==DEPTH and no pop is dropped.
  - A drop sets overflow=1 and increments drop_count, saturating at 255.
  - FIFO contents are unchanged.
- Pop: occurs when rd_valid && rd_ready at the posedge. The head advances. rd_ready while empty has no effect.
- Read port:
  - FWFT. rd_res/rd_tag/rd_op are driven from the head entry whenever rd_valid=1.
  - They hold the last popped values (0 after reset) when the FIFO is empty.
  - Latency from an arrival into an empty FIFO to rd_valid=1 is 1 cycle: visible after the capturing edge.
- Occupancy: count = previous count + push − pop. Push and pop together leave count unchanged.
- Pointers: AW-bit, wrap modulo DEPTH. Full/empty is derived from count, not from pointer equality.
- Sequence checker (evaluated on every arrival, pushed or dropped):
  - If out_databits != expected: set seq_error=1. If seq_error was 0 before this edge, also load err_tag=out_databits.
  - In all cases, expected <= out_databits+1, modulo 2^DATABITS; 127 wraps to 0. The checker resyncs after an error.
- Clear (clear=1 at posedge):
  - Zeroes overflow, drop_count, seq_error and err_tag.
  - Does not flush the FIFO or alter the expected tag.
  - A drop or sequence error in the same cycle as clear wins: the flag sets and the counter becomes 1, err_tag is loaded.
- Reset mid-operation: all entries are lost and rd_valid falls immediately on reset assertion. The first arrival after reset is expected to carry tag 0.
- No combinational path from rd_ready to rd_valid or the rd_* outputs.

Test Plan:
- Basic: after reset, apply ADD res=5 tag=0, then NOP, then SUB res=0xFFFFFFFF tag=1, with rd_ready=0 -> count=2. Head shows res=5, tag=0, op=1. Pop once -> head shows 0xFFFFFFFF, tag=1, op=2. Pop again -> rd_valid=0. seq_error stays 0 throughout.
- Full/overflow: push tags 0..7 with rd_ready=0 -> count=8. Push tag 8 -> dropped, overflow=1, drop_count=1. Push tag 9 with rd_ready=1 in the same cycle -> accepted, count stays 8, overflow stays 1. Drain the FIFO -> tags read out 1..7 then 9.
- Sequence: push tags 0,1,3,4 -> seq_error=1, err_tag=3, and no error at tag 4. Push tag 9 -> err_tag remains 3. Pulse clear -> seq_error=0, err_tag=0.
- Wrap: push tags 126,127,0,1 after presetting expected via an arrival of tag 125 -> no new seq_error across the 127->0 wrap. Pointer wrap: 20 push/pop pairs at count=1 return data in order.
- Clear/event collision: with FIFO full, drop an arrival in the same cycle clear=1 -> overflow=1, drop_count=1. Saturation: 300 consecutive drops -> drop_count=255.
- Reset mid-stream: with count=5, assert reset=0 between edges -> rd_valid=0, count=0 immediately. After release, tag 0 arrives -> no seq_error.

Source files
------------

// File: rtl/alu_result_collector.sv
// alu_result_collector
//   Sink for the pipelined ALU result stream. Every non-NOP result is
//   captured with its tag and opcode into a first-word-fall-through FIFO
//   that is drained through a valid/ready read port. Result tags are also
//   checked for consecutive order, and drops and sequence errors are flagged.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous reset, active-low
//   res           ALU result data
//   out_databits  ALU result tag
//   out_op        ALU result opcode (0=NOP, 1=ADD, 2=SUB, 3=MULT)
//   rd_ready      consumer accepts the head entry
//   clear         synchronous clear of status flags and counters
//   rd_valid      FIFO non-empty
//   rd_res        head entry result (last popped value when empty)
//   rd_tag        head entry tag    (last popped value when empty)
//   rd_op         head entry opcode (last popped value when empty)
//   count         current occupancy, 0..DEPTH
//   overflow      sticky: a result was dropped because the FIFO was full
//   drop_count    saturating count of dropped results
//   seq_error     sticky: a tag arrived out of sequence
//   err_tag       tag that caused the first uncleared sequence error
module alu_result_collector #(
    parameter int WIDTH    = 32,
    parameter int DATABITS = 7,
    parameter int DEPTH    = 8,
    parameter int AW       = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    res,
    input  logic [DATABITS-1:0] out_databits,
    input  logic [1:0]          out_op,
    input  logic                rd_ready,
    input  logic                clear,
    output logic                rd_valid,
    output logic [WIDTH-1:0]    rd_res,
    output logic [DATABITS-1:0] rd_tag,
    output logic [1:0]          rd_op,
    output logic [AW:0]         count,
    output logic                overflow,
    output logic [7:0]          drop_count,
    output logic                seq_error,
    output logic [DATABITS-1:0] err_tag
);

    localparam int EW = WIDTH + DATABITS + 2;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [EW-1:0]       mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic [EW-1:0]       last_q, last_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic                seq_err_q, seq_err_d;
    logic [DATABITS-1:0] err_tag_q, err_tag_d;
    logic [DATABITS-1:0] exp_tag_q, exp_tag_d;

    logic          arrival, full, pop, push, drop, mismatch;
    logic [EW-1:0] head;

    assign head     = mem_q[rd_ptr_q];
    assign arrival  = (out_op != 2'd0);
    assign full     = (count_q == FULL_CNT);
    assign rd_valid = (count_q != '0);
    assign pop      = rd_valid && rd_ready;
    // A pop in the same cycle frees the slot the arrival needs.
    assign push     = arrival && (!full || pop);
    assign drop     = arrival && full && !pop;
    assign mismatch = arrival && (out_databits != exp_tag_q);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        last_d     = last_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        seq_err_d  = seq_err_q;
        err_tag_d  = err_tag_q;
        exp_tag_d  = exp_tag_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            last_d   = head;
        end
        if (push && !pop)      count_d = count_q + (AW+1)'(1);
        else if (pop && !push) count_d = count_q - (AW+1)'(1);

        if (clear) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
            seq_err_d  = 1'b0;
            err_tag_d  = '0;
        end

        // Events override a same-cycle clear; drop_cnt_d is already 0 then.
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'd1;
        end

        if (mismatch) begin
            seq_err_d = 1'b1;
            if (!seq_err_q || clear) err_tag_d = out_databits;
        end

        // The checker resyncs on every arrival, matched or not.
        if (arrival) exp_tag_d = out_databits + DATABITS'(1);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {res, out_databits, out_op};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            seq_err_q  <= 1'b0;
            err_tag_q  <= '0;
            exp_tag_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            seq_err_q  <= seq_err_d;
            err_tag_q  <= err_tag_d;
            exp_tag_q  <= exp_tag_d;
        end
    end

    // Head entry while non-empty, otherwise the last popped entry.
    assign {rd_res, rd_tag, rd_op} = rd_valid ? head : last_q;

    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;
    assign seq_error  = seq_err_q;
    assign err_tag    = err_tag_q;

endmodule

// File: tb/tb_alu_result_collector.sv
module tb_alu_result_collector;

    localparam int WIDTH    = 32;
    localparam int DATABITS = 7;
    localparam int DEPTH    = 8;
    localparam int AW       = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic [WIDTH-1:0]    res;
    logic [DATABITS-1:0] out_databits;
    logic [1:0]          out_op;
    logic                rd_ready;
    logic                clear;
    logic                rd_valid;
    logic [WIDTH-1:0]    rd_res;
    logic [DATABITS-1:0] rd_tag;
    logic [1:0]          rd_op;
    logic [AW:0]         count;
    logic                overflow;
    logic [7:0]          drop_count;
    logic                seq_error;
    logic [DATABITS-1:0] err_tag;

    alu_result_collector #(
        .WIDTH(WIDTH), .DATABITS(DATABITS), .DEPTH(DEPTH), .AW(AW)
    ) dut (
        .clk(clk), .reset(reset), .res(res), .out_databits(out_databits),
        .out_op(out_op), .rd_ready(rd_ready), .clear(clear),
        .rd_valid(rd_valid), .rd_res(rd_res), .rd_tag(rd_tag), .rd_op(rd_op),
        .count(count), .overflow(overflow), .drop_count(drop_count),
        .seq_error(seq_error), .err_tag(err_tag)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of captured results plus status bookkeeping.
    typedef struct {
        int unsigned r;
        int unsigned t;
        int unsigned o;
    } ent_t;

    ent_t q[$];
    ent_t last;
    int   m_exp;
    bit   m_ovf;
    int   m_drop;
    bit   m_seq;
    int   m_err;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last   = '{0, 0, 0};
        m_exp  = 0;
        m_ovf  = 0;
        m_drop = 0;
        m_seq  = 0;
        m_err  = 0;
    endtask

    task automatic model_update(input int op, input int tag, input int unsigned r,
                                input bit rdy, input bit clr);
        bit pop, arr, full, prior;
        ent_t e;
        prior = m_seq;
        pop   = (q.size() > 0) && rdy;
        arr   = (op != 0);
        full  = (q.size() == DEPTH);
        if (clr) begin
            m_ovf = 0; m_drop = 0; m_seq = 0; m_err = 0;
        end
        if (arr) begin
            if (full && !pop) begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
            if (tag != m_exp) begin
                if (!prior || clr) m_err = tag;
                m_seq = 1;
            end
            m_exp = (tag + 1) % 128;
        end
        if (pop) last = q.pop_front();
        if (arr && !(full && !pop)) begin
            e = '{r, tag, op};
            q.push_back(e);
        end
    endtask

    task automatic check_all();
        ent_t h;
        h = (q.size() > 0) ? q[0] : last;
        chk("rd_valid",   rd_valid,   (q.size() > 0));
        chk("count",      count,      q.size());
        chk("rd_res",     rd_res,     h.r);
        chk("rd_tag",     rd_tag,     h.t);
        chk("rd_op",      rd_op,      h.o);
        chk("overflow",   overflow,   m_ovf);
        chk("drop_count", drop_count, m_drop);
        chk("seq_error",  seq_error,  m_seq);
        chk("err_tag",    err_tag,    m_err);
    endtask

    // One clock: drive inputs, advance the model, then sample 1ns after the edge.
    task automatic step(input int op, input int tag, input int unsigned r,
                        input bit rdy, input bit clr);
        out_op       = 2'(op);
        out_databits = 7'(tag);
        res          = r;
        rd_ready     = rdy;
        clear        = clr;
        model_update(op, tag, r, rdy, clr);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int drain_exp[8];
        int op, tag;

        reset = 1'b0; res = '0; out_databits = '0; out_op = '0;
        rd_ready = 1'b0; clear = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Basic capture and FWFT read-out
        step(1, 0, 5, 0, 0);
        chk("basic_valid_latency", rd_valid, 1);
        step(0, 0, 0, 0, 0);
        step(2, 1, 32'hFFFF_FFFF, 0, 0);
        chk("basic_count", count, 2);
        chk("basic_head_res", rd_res, 5);
        chk("basic_head_op", rd_op, 1);
        step(0, 0, 0, 1, 0);
        chk("basic_pop1_res", rd_res, 32'hFFFF_FFFF);
        chk("basic_pop1_tag", rd_tag, 1);
        step(0, 0, 0, 1, 0);
        chk("basic_empty", rd_valid, 0);
        chk("basic_hold_res", rd_res, 32'hFFFF_FFFF);
        step(0, 0, 0, 1, 0);

        // Full, drop, push with simultaneous pop, drain
        do_reset();
        for (int i = 0; i < 8; i++) step(1, i, 100 + i, 0, 0);
        chk("full_count", count, 8);
        step(3, 8, 108, 0, 0);
        chk("full_overflow", overflow, 1);
        chk("full_drop", drop_count, 1);
        step(2, 9, 109, 1, 0);
        chk("full_pushpop_count", count, 8);
        drain_exp = '{1, 2, 3, 4, 5, 6, 7, 9};
        for (int i = 0; i < 8; i++) begin
            chk("drain_tag", rd_tag, drain_exp[i]);
            step(0, 0, 0, 1, 0);
        end
        chk("drain_empty", rd_valid, 0);

        // Sequence checker
        do_reset();
        step(1, 0, 1, 1, 0);
        step(1, 1, 2, 1, 0);
        step(1, 3, 3, 1, 0);
        chk("seq_flag", seq_error, 1);
        chk("seq_err_tag", err_tag, 3);
        step(1, 4, 4, 1, 0);
        step(1, 9, 5, 1, 0);
        chk("seq_err_tag_held", err_tag, 3);
        step(0, 0, 0, 1, 1);
        chk("seq_clear_flag", seq_error, 0);
        chk("seq_clear_tag", err_tag, 0);

        // Tag wrap 127 -> 0
        do_reset();
        step(1, 125, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        step(1, 126, 1, 1, 0);
        step(1, 127, 2, 1, 0);
        step(1, 0, 3, 1, 0);
        step(1, 1, 4, 1, 0);
        chk("wrap_no_seq", seq_error, 0);

        // Pointer wrap at count=1
        do_reset();
        step(1, 0, $urandom, 0, 0);
        for (int i = 1; i <= 20; i++) step(1, i, $urandom, 1, 0);
        chk("ptrwrap_count", count, 1);
        chk("ptrwrap_tag", rd_tag, 20);

        // Drop colliding with clear, then saturation
        do_reset();
        for (int i = 0; i < 8; i++) step(1, i, i, 0, 0);
        step(1, 8, 8, 0, 0);
        step(1, 9, 9, 0, 1);
        chk("collide_overflow", overflow, 1);
        chk("collide_drop", drop_count, 1);
        for (int i = 0; i < 300; i++) step(2, (10 + i) % 128, i, 0, 0);
        chk("sat_drop", drop_count, 255);

        // Reset asserted between edges with count=5
        do_reset();
        for (int i = 0; i < 5; i++) step(1, i, i, 0, 0);
        chk("mid_count", count, 5);
        #2;
        do_reset();
        chk("mid_valid", rd_valid, 0);
        step(1, 0, 77, 0, 0);
        chk("mid_seq", seq_error, 0);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            op  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 3));
            tag = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : m_exp;
            step(op, tag, $urandom, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 49) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
